fft_mag_scheduler: RTL
======================

# fft_mag_scheduler

Sequenced magnitude stage for the 4-point FFT output. It accepts one frame of four complex bins over a valid/ready handshake and time-multiplexes a single alpha-max-plus-beta-min unit (alpha = 1, beta = 0.5) across the bins, one bin per cycle. It then presents the four 8-bit magnitudes, and optionally the peak bin, over a valid/ready output handshake. It replaces four parallel magnitude units with one shared unit plus a small FSM.

## Interface
- DATA_W, 16, width of each signed two's-complement real/imag input.
- MAG_W, 8, output magnitude width; the output is the top MAG_W bits of the DATA_W-bit result. Requires MAG_W ≤ DATA_W.

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input frame valid.
- in_ready  out  1  block can accept a frame; equals (state == IDLE).
- X0_real, X0_imag … X3_real, X3_imag  in  DATA_W each  signed bin values; sampled only on the accept edge.
- out_valid  out  1  magnitudes valid; held until accepted.
- out_ready  in  1  downstream accepts the output.
- X0_mag, X1_mag, X2_mag, X3_mag  out  MAG_W each  registered magnitudes.
- peak_idx  out  2  index of the largest bin.
- peak_mag  out  MAG_W  magnitude of the largest bin.
- busy  out  1  high in CALC.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready = 1. On in_valid && in_ready:
  - latch all eight inputs into the frame register;
  - idx ← 0;
  - go to CALC.
- CALC: each cycle, for bin idx:
  - a = |re|, b = |im|, computed as (x ^ {DATA_W{sign}}) + sign, unsigned DATA_W bits;
  - max = (a > b) ? a : b; min = the other;
  - r = max + (min >> 1), DATA_W bits;
  - Xidx_mag ← r[DATA_W-1 -: MAG_W];
  - idx increments; after idx == 3 is written, go to DONE.
- Arithmetic: |−2^(DATA_W−1)| = 2^(DATA_W−1) fits unsigned. The worst case is 0x8000 + 0x4000 = 0xC000, so r never overflows and needs no saturation.
- DONE: out_valid = 1; outputs and peak are stable. On out_valid && out_ready: go to IDLE, out_valid ← 0. Mag registers hold their values until overwritten by the next frame.
- in_valid outside IDLE is ignored; there is no input buffering.
- out_ready outside DONE is ignored.
- The frame register is written only on the accept edge. Input changes during CALC/DONE have no effect.
- Reset (any state, including mid-CALC or DONE):
  - state → IDLE, idx → 0;
  - the partial frame is discarded;
  - out_valid = 0, busy = 0;
  - all X*_mag = 0, peak_idx = 0, peak_mag = 0.
  - in_ready = 1 from the first cycle after reset. Inputs are ignored while rst is high.

## Timing
- Accept edge E0 → CALC.
- Edges E1..E4 write X0_mag..X3_mag respectively. State is DONE after E4, so out_valid is high from E4 onward: latency 4 cycles.
- busy is high in the cycles between E0 and E4.
- If out_ready is high, the handshake happens at E5 and in_ready is high after E5. The next accept is at E6 at the earliest, so minimum frame period is 6 cycles.
- out_ready held low stalls indefinitely in DONE with all outputs stable.

## Configuration
- FFT_MAG_PEAK_EN defined:
  - During CALC, a running peak is kept on the full DATA_W result r.
  - Bin 0 initialises it; a later bin replaces it only if strictly greater, so a tie keeps the lowest index.
  - peak_idx/peak_mag update at E4 together with X3_mag and are valid with out_valid.
- Not defined: the peak logic is not compiled; peak_idx and peak_mag are tied to 0. Ports remain present.

## Test plan
- Reset then frame X0=(0x1000,0x0800), X1=(−0x2000,0), X2=(0x0100,−0x0300), X3=(0x8000,0x8000) → out_valid 4 cycles after accept; mags 0x14, 0x20, 0x03, 0xC0; with PEAK_EN, peak_idx=3 and peak_mag=0xC0.
- Tie: X0=X2=(0x4000,0), X1=X3=(0,0) → mags 0x40, 0x00, 0x40, 0x00; peak_idx=0.
- Backpressure: out_ready low for 10 cycles after out_valid → outputs stable, in_ready=0, a new in_valid is ignored. Raise out_ready → one-cycle handshake, in_ready=1 the next cycle.
- Back-to-back: in_valid and out_ready held high with two different frames → second accept exactly 6 cycles after the first; the second frame's results are correct.
- Reset asserted at E2 mid-CALC → the next cycle shows IDLE, in_ready=1, out_valid=0, all mags and peak 0. A following frame then completes normally.
- Input change during CALC: change all X inputs at E1 → results reflect only the values latched at E0.

Source files
------------

// File: rtl/fft_mag_scheduler.sv
// fft_mag_scheduler: accepts one frame of four complex FFT bins, then runs a
// single alpha-max-plus-beta-min unit (alpha = 1, beta = 0.5) over the bins,
// one bin per cycle. The four MAG_W-bit magnitudes are presented on a
// valid/ready output handshake.
// Optional feature: define FFT_MAG_PEAK_EN to also track the peak bin
// (strictly greater wins, so a tie keeps the lowest index). Without it,
// peak_idx and peak_mag are tied to zero.
module fft_mag_scheduler #(
    parameter int DATA_W = 16,
    parameter int MAG_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] X0_real,
    input  logic signed [DATA_W-1:0] X0_imag,
    input  logic signed [DATA_W-1:0] X1_real,
    input  logic signed [DATA_W-1:0] X1_imag,
    input  logic signed [DATA_W-1:0] X2_real,
    input  logic signed [DATA_W-1:0] X2_imag,
    input  logic signed [DATA_W-1:0] X3_real,
    input  logic signed [DATA_W-1:0] X3_imag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [MAG_W-1:0]         X0_mag,
    output logic [MAG_W-1:0]         X1_mag,
    output logic [MAG_W-1:0]         X2_mag,
    output logic [MAG_W-1:0]         X3_mag,
    output logic [1:0]               peak_idx,
    output logic [MAG_W-1:0]         peak_mag,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_reg;
    logic [1:0]        idx_reg;
    logic              out_valid_reg;
    logic              busy_reg;
    logic [DATA_W-1:0] in_re [4];
    logic [DATA_W-1:0] in_im [4];
    logic [DATA_W-1:0] re_reg [4];
    logic [DATA_W-1:0] im_reg [4];
    logic [MAG_W-1:0]  mag_reg [4];

    // Shared magnitude datapath signals for the bin selected by idx_reg
    logic [DATA_W-1:0] cur_re;
    logic [DATA_W-1:0] cur_im;
    logic [DATA_W-1:0] abs_re;
    logic [DATA_W-1:0] abs_im;
    logic [DATA_W-1:0] max_v;
    logic [DATA_W-1:0] min_v;
    logic [DATA_W-1:0] r;

    assign in_re[0] = X0_real;
    assign in_im[0] = X0_imag;
    assign in_re[1] = X1_real;
    assign in_im[1] = X1_imag;
    assign in_re[2] = X2_real;
    assign in_im[2] = X2_imag;
    assign in_re[3] = X3_real;
    assign in_im[3] = X3_imag;

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign X0_mag    = mag_reg[0];
    assign X1_mag    = mag_reg[1];
    assign X2_mag    = mag_reg[2];
    assign X3_mag    = mag_reg[3];

    // Alpha-max-plus-beta-min on the current bin; |-2^(W-1)| fits unsigned
    // and the worst-case sum is 0.75 * 2^W, so r cannot overflow.
    always_comb begin
        cur_re = re_reg[idx_reg];
        cur_im = im_reg[idx_reg];
        abs_re = (cur_re ^ {DATA_W{cur_re[DATA_W-1]}})
               + {{(DATA_W-1){1'b0}}, cur_re[DATA_W-1]};
        abs_im = (cur_im ^ {DATA_W{cur_im[DATA_W-1]}})
               + {{(DATA_W-1){1'b0}}, cur_im[DATA_W-1]};
        if (abs_re > abs_im) begin
            max_v = abs_re;
            min_v = abs_im;
        end else begin
            max_v = abs_im;
            min_v = abs_re;
        end
        r = max_v + (min_v >> 1);
    end

    // Control FSM: frame capture, bin sequencing, magnitude write-back, output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= 2'd0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                mag_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < 4; i++) begin
                            re_reg[i] <= in_re[i];
                            im_reg[i] <= in_im[i];
                        end
                        idx_reg   <= 2'd0;
                        busy_reg  <= 1'b1;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    mag_reg[idx_reg] <= r[DATA_W-1 -: MAG_W];
                    idx_reg          <= idx_reg + 2'd1;
                    if (idx_reg == 2'd3) begin
                        busy_reg      <= 1'b0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef FFT_MAG_PEAK_EN
    logic [DATA_W-1:0] run_val_reg;
    logic [1:0]        run_idx_reg;
    logic [1:0]        peak_idx_reg;
    logic [MAG_W-1:0]  peak_mag_reg;
    logic              take;
    logic [DATA_W-1:0] best_val;
    logic [1:0]        best_idx;

    // Bin 0 seeds the running peak; later bins replace it only when strictly larger
    always_comb begin
        take     = (idx_reg == 2'd0) || (r > run_val_reg);
        best_val = take ? r : run_val_reg;
        best_idx = take ? idx_reg : run_idx_reg;
    end

    // Running peak during CALC; published together with the last magnitude
    always_ff @(posedge clk) begin
        if (rst) begin
            run_val_reg  <= '0;
            run_idx_reg  <= 2'd0;
            peak_idx_reg <= 2'd0;
            peak_mag_reg <= '0;
        end else if (state_reg == CALC) begin
            run_val_reg <= best_val;
            run_idx_reg <= best_idx;
            if (idx_reg == 2'd3) begin
                peak_idx_reg <= best_idx;
                peak_mag_reg <= best_val[DATA_W-1 -: MAG_W];
            end
        end
    end

    assign peak_idx = peak_idx_reg;
    assign peak_mag = peak_mag_reg;
`else
    assign peak_idx = 2'd0;
    assign peak_mag = '0;
`endif

endmodule
